// File: rtl/graphics_pkg.sv
// Shared playfield geometry and controller state encoding for the
// double-buffered framebuffer swap logic.
package graphics_pkg;

  localparam int XMAX        = 240;
  localparam int YMAX        = 264;
  localparam int VACTIVE     = 480;
  localparam int FB_ADDR_MAX = XMAX * YMAX - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WAIT_VB,
    ST_SWAP
  } fb_state_e;

endpackage

// File: rtl/fb_fill_counter.sv
// Column-major fill coordinate tracker: y runs fastest, x steps when y wraps,
// and a linear address runs alongside so no multiplier is needed.
module fb_fill_counter #(
  parameter int XMAX = graphics_pkg::XMAX,
  parameter int YMAX = graphics_pkg::YMAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        advance,
  output logic [7:0]  x,
  output logic [8:0]  y,
  output logic [15:0] addr,
  output logic        last
);
  import graphics_pkg::*;

  localparam logic [7:0] X_LAST = 8'(XMAX - 1);
  localparam logic [8:0] Y_LAST = 9'(YMAX - 1);

  assign last = (x == X_LAST) && (y == Y_LAST);

  // Step to the next pixel on each accepted write; the final pixel wraps everything to 0.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (advance) begin
      if (last) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
      end else begin
        addr <= addr + 16'd1;
        if (y == Y_LAST) begin
          y <= '0;
          x <= x + 8'd1;
        end else begin
          y <= y + 9'd1;
        end
      end
    end
  end

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffer controller: renders a frame into the back bank, then waits for
// the next vertical blanking edge to flip which bank the VGA path displays.
module fb_swap_ctrl #(
  parameter int XMAX    = graphics_pkg::XMAX,
  parameter int YMAX    = graphics_pkg::YMAX,
  parameter int VACTIVE = graphics_pkg::VACTIVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  vc,
  input  logic        render_req,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic [7:0]  fill_x,
  output logic [8:0]  fill_y,
  output logic [1:0]  wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        disp_bank,
  output logic        swap,
  output logic        frame_drop,
  output logic        busy
);
  import graphics_pkg::*;

  localparam logic [9:0] VB_LINE = 10'(VACTIVE);

  fb_state_e state, state_next;
  logic      disp_q;
  logic      vb_hist;
  logic      vb_now;
  logic      vb_edge;
  logic      fill_active;
  logic      transfer;
  logic      last;
  logic      clear;

  assign vb_now      = (vc >= VB_LINE);
  assign vb_edge     = vb_now & ~vb_hist;
  assign fill_active = (state == ST_FILL) & rst;
  assign transfer    = fill_active & pix_valid;

  assign pix_ready = fill_active;
  assign wr_en     = transfer ? (disp_q ? 2'b01 : 2'b10) : 2'b00;
  assign wr_data   = pix_data;
  assign disp_bank = disp_q;

  fb_fill_counter #(
    .XMAX (XMAX),
    .YMAX (YMAX)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (transfer),
    .x       (fill_x),
    .y       (fill_y),
    .addr    (wr_addr),
    .last    (last)
  );

  // State, displayed bank and vblank history; history starts high so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      disp_q  <= 1'b0;
      vb_hist <= 1'b1;
    end else begin
      state   <= state_next;
      vb_hist <= vb_now;
      if (state == ST_SWAP) begin
        disp_q <= ~disp_q;
      end
    end
  end

  // Next state and pulses; a vblank edge that lands on the final write is not a drop.
  always_comb begin
    state_next = state;
    swap       = 1'b0;
    frame_drop = 1'b0;
    clear      = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (render_req) begin
          state_next = ST_FILL;
          clear      = 1'b1;
        end
      end
      ST_FILL: begin
        busy = 1'b1;
        if (transfer && last) begin
          state_next = ST_WAIT_VB;
        end else if (vb_edge) begin
          frame_drop = rst;
        end
      end
      ST_WAIT_VB: begin
        busy = 1'b1;
        if (vb_edge) begin
          state_next = ST_SWAP;
        end
      end
      ST_SWAP: begin
        swap       = rst;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Self-checking bench for fb_swap_ctrl: a frame-level reference model counts
// pixels written and tracks fill / wait / swap phases, and every cycle the
// DUT outputs are compared against what that model predicts.
module tb_fb_swap_ctrl;

  localparam int XMAX    = 240;
  localparam int YMAX    = 264;
  localparam int VACTIVE = 480;
  localparam int TOTAL   = XMAX * YMAX;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  vc = '0;
  logic        render_req = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        pix_ready;
  logic [7:0]  fill_x;
  logic [8:0]  fill_y;
  logic [1:0]  wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        disp_bank;
  logic        swap;
  logic        frame_drop;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  // Reference model: frame in progress, frame complete, swap cycle, shown bank, pixels written.
  bit m_active  = 1'b0;
  bit m_done    = 1'b0;
  bit m_swap    = 1'b0;
  bit m_disp    = 1'b0;
  bit m_prev_vb = 1'b1;
  int m_count   = 0;

  fb_swap_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .vc         (vc),
    .render_req (render_req),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .fill_x     (fill_x),
    .fill_y     (fill_y),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .disp_bank  (disp_bank),
    .swap       (swap),
    .frame_drop (frame_drop),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic bit model_xfer();
    return (rst === 1'b1) && m_active && (pix_valid === 1'b1);
  endfunction

  function automatic bit model_edge();
    return (int'(vc) >= VACTIVE) && !m_prev_vb;
  endfunction

  // Expected outputs for the current cycle, derived from the pixel count and frame phase.
  function automatic logic [47:0] model_expect();
    bit          xf;
    bit          run;
    logic [1:0]  ew;
    logic        drop;
    xf   = model_xfer();
    run  = (rst === 1'b1) && m_active;
    ew   = xf ? (m_disp ? 2'b01 : 2'b10) : 2'b00;
    drop = run && model_edge() && !(xf && (m_count == TOTAL - 1));
    return {run, 8'(m_count / YMAX), 9'(m_count % YMAX), ew, 16'(m_count),
            (xf ? pix_data : 8'h00), m_disp, ((rst === 1'b1) && m_swap), drop,
            (m_active || m_done)};
  endfunction

  function automatic void model_update();
    bit e;
    bit xf;
    if (rst !== 1'b1) begin
      m_active  = 1'b0;
      m_done    = 1'b0;
      m_swap    = 1'b0;
      m_disp    = 1'b0;
      m_prev_vb = 1'b1;
      m_count   = 0;
    end else begin
      e  = model_edge();
      xf = model_xfer();
      m_prev_vb = (int'(vc) >= VACTIVE);
      if (m_swap) begin
        m_disp = !m_disp;
        m_swap = 1'b0;
      end else if (m_done) begin
        if (e) begin
          m_done = 1'b0;
          m_swap = 1'b1;
        end
      end else if (m_active) begin
        if (xf) begin
          m_count++;
          if (m_count == TOTAL) begin
            m_count  = 0;
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
      end else if (render_req === 1'b1) begin
        m_active = 1'b1;
        m_count  = 0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic sample(output logic [47:0] obs, output logic [47:0] exp);
    #1;
    exp = model_expect();
    obs = {pix_ready, fill_x, fill_y, wr_en, wr_addr, (model_xfer() ? wr_data : 8'h00),
           disp_bank, swap, frame_drop, busy};
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    render_req = 1'b0;
    pix_valid  = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [47:0] obs, exp;
    vc = 10'd600;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      vc = (i == 3) ? 10'd0 : 10'd600;
      sample(obs, exp);
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL reset cyc=%0d got %h want %h", i, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_full_fill();
    logic [47:0] obs, exp;
    int writes = 0;
    int swaps  = 0;
    int drops  = 0;
    int cyc    = 0;
    vc         = 10'd0;
    render_req = 1'b1;
    sample(obs, exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL full_start got %h want %h", obs, exp);
    end
    tick();
    render_req = 1'b0;
    pix_valid  = 1'b1;
    while ((m_active || cyc == 0) && cyc < 70000) begin
      vc       = (m_count == TOTAL - 1) ? 10'd480 : 10'd0;
      pix_data = 8'($urandom);
      sample(obs, exp);
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL full_fill cyc=%0d got %h want %h", cyc, obs, exp);
      end
      if (wr_en == 2'b10) writes++;
      if (swap) swaps++;
      if (frame_drop) drops++;
      tick();
      cyc++;
    end
    checks++;
    if (m_active) begin
      fails++;
      $display("[TB] FAIL full_fill_timeout cycles=%0d required completion", cyc);
    end
    pix_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vc         = (i < 2) ? 10'd480 : (i < 4) ? 10'd0 : (i == 4) ? 10'd479 : 10'd480;
      render_req = m_done || m_swap;
      sample(obs, exp);
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL full_swap cyc=%0d got %h want %h", i, obs, exp);
      end
      if (wr_en != 2'b00) writes++;
      if (swap) swaps++;
      if (frame_drop) drops++;
      tick();
    end
    render_req = 1'b0;
    checks++;
    if (writes != TOTAL) begin
      fails++;
      $display("[TB] FAIL full_writes got %0d want %0d", writes, TOTAL);
    end
    checks++;
    if (swaps != 1) begin
      fails++;
      $display("[TB] FAIL full_swaps got %0d want 1", swaps);
    end
    checks++;
    if (drops != 0) begin
      fails++;
      $display("[TB] FAIL full_drops got %0d want 0", drops);
    end
    checks++;
    if (disp_bank !== 1'b1) begin
      fails++;
      $display("[TB] FAIL full_disp got %b want 1", disp_bank);
    end
  endtask

  task automatic test_frame_drop();
    logic [47:0] obs, exp;
    int drops       = 0;
    int resume_addr = -1;
    int cyc         = 0;
    vc = 10'd0;
    do_reset();
    render_req = 1'b1;
    tick();
    render_req = 1'b0;
    while (m_count < 1000 && cyc < 5000) begin
      pix_valid = ($urandom_range(0, 9) < 7);
      pix_data  = 8'($urandom);
      if (m_count == 999 && pix_valid) vc = 10'd0;
      sample(obs, exp);
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL drop_fill cyc=%0d got %h want %h", cyc, obs, exp);
      end
      tick();
      cyc++;
    end
    pix_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      vc        = (i < 2) ? 10'd479 : (i < 5) ? 10'd480 : 10'd0;
      pix_valid = (i >= 5);
      pix_data  = 8'($urandom);
      sample(obs, exp);
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL drop_stall cyc=%0d got %h want %h", i, obs, exp);
      end
      if (frame_drop) drops++;
      if (wr_en != 2'b00 && resume_addr < 0) resume_addr = int'(wr_addr);
      tick();
    end
    pix_valid = 1'b0;
    checks++;
    if (drops != 1) begin
      fails++;
      $display("[TB] FAIL drop_count got %0d want 1", drops);
    end
    checks++;
    if (resume_addr != 1000) begin
      fails++;
      $display("[TB] FAIL drop_resume got %0d want 1000", resume_addr);
    end
    checks++;
    if (disp_bank !== 1'b0) begin
      fails++;
      $display("[TB] FAIL drop_disp got %b want 0", disp_bank);
    end
  endtask

  task automatic test_toggle_valid();
    logic [47:0] obs, exp;
    int writes = 0;
    vc = 10'd0;
    do_reset();
    render_req = 1'b1;
    tick();
    render_req = 1'b0;
    for (int i = 0; i < 600; i++) begin
      pix_valid = (i % 2 == 0);
      pix_data  = 8'($urandom);
      sample(obs, exp);
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL toggle cyc=%0d got %h want %h", i, obs, exp);
      end
      if (wr_en == 2'b10) writes++;
      tick();
    end
    pix_valid = 1'b0;
    checks++;
    if (writes != 300 || wr_addr !== 16'd300) begin
      fails++;
      $display("[TB] FAIL toggle_writes got %0d addr %0d want 300", writes, wr_addr);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [47:0] obs, exp;
    int cyc = 0;
    vc = 10'd0;
    do_reset();
    render_req = 1'b1;
    tick();
    render_req = 1'b0;
    pix_valid  = 1'b1;
    while (m_count < 500 && cyc < 1000) begin
      pix_data = 8'($urandom);
      tick();
      cyc++;
    end
    rst = 1'b0;
    vc  = 10'd480;
    sample(obs, exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL rstmid_assert got %h want %h", obs, exp);
    end
    tick();
    rst = 1'b1;
    pix_valid = 1'b0;
    sample(obs, exp);
    checks++;
    if (obs !== 48'h0) begin
      fails++;
      $display("[TB] FAIL rstmid_cleared got %h want %h", obs, 48'h0);
    end
    tick();
    render_req = 1'b1;
    tick();
    render_req = 1'b0;
    pix_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pix_data = 8'($urandom);
      sample(obs, exp);
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL rstmid_restart cyc=%0d got %h want %h", i, obs, exp);
      end
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_random_req();
    logic [47:0] obs, exp;
    vc = 10'd0;
    do_reset();
    render_req = 1'b1;
    tick();
    for (int i = 0; i < 1500; i++) begin
      render_req = ($urandom_range(0, 3) == 0);
      pix_valid  = ($urandom_range(0, 1) == 1);
      pix_data   = 8'($urandom);
      vc         = 10'($urandom_range(470, 490));
      sample(obs, exp);
      checks++;
      if (obs !== exp) begin
        fails++;
        $display("[TB] FAIL random cyc=%0d got %h want %h", i, obs, exp);
      end
      tick();
    end
    render_req = 1'b0;
    pix_valid  = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_fill();
    test_frame_drop();
    test_toggle_valid();
    test_reset_mid_fill();
    test_random_req();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/fb_swap_ctrl.md
FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

Interface
REQ-001 Parameter XMAX, default 240, playfield columns.
REQ-002 Parameter YMAX, default 264, playfield rows held in RAM.
REQ-003 Parameter VACTIVE, default 480, first blanking line.
REQ-004 clk  in  1  system clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 vc  in  10  VGA vertical counter.
REQ-007 render_req  in  1  one-cycle pulse: game state updated, render new frame.
REQ-008 pix_valid  in  1  renderer has pixel for current fill coordinate.
REQ-009 pix_data  in  8  RRRGGGBB pixel colour.
REQ-010 pix_ready  out  1  controller accepts pixel.
REQ-011 fill_x  out  8  column being rendered, 0..XMAX-1.
REQ-012 fill_y  out  9  row being rendered, 0..YMAX-1.
REQ-013 wr_en  out  2  one-hot write enable per bank; bit = back bank.
REQ-014 wr_addr  out  16  write address, fill_x*YMAX+fill_y.
REQ-015 wr_data  out  8  pixel data to RAM.
REQ-016 disp_bank  out  1  bank the VGA read path displays.
REQ-017 swap  out  1  one-cycle pulse on bank exchange.
REQ-018 frame_drop  out  1  one-cycle pulse: vblank reached with fill incomplete.
REQ-019 busy  out  1  high in FILL or WAIT_VB.

Function
REQ-020 States IDLE, FILL, WAIT_VB, SWAP; encoded in shared enum.
REQ-021 IDLE: pix_ready=0; render_req -> FILL with fill_x=0, fill_y=0, wr_addr=0.
REQ-022 FILL: pix_ready=1; transfer = pix_valid & pix_ready.
REQ-023 On transfer: wr_en[~disp_bank]=1, wr_data=pix_data, wr_addr current, same cycle (combinational from registered coords).
REQ-024 No transfer -> wr_en=0, coordinates hold.
REQ-025 fill_y increments per transfer; at YMAX-1 wraps to 0 and fill_x increments; wr_addr increments by 1 every transfer (linear, no multiplier).
REQ-026 Transfer at fill_x=XMAX-1, fill_y=YMAX-1 (wr_addr 63359) -> WAIT_VB next cycle, pix_ready=0.
REQ-027 vblank edge = registered (vc>=VACTIVE) rising; one-cycle internal pulse.
REQ-028 WAIT_VB + vblank edge -> SWAP; SWAP lasts one cycle: disp_bank toggles, swap=1, then IDLE.
REQ-029 FILL + vblank edge -> frame_drop=1; fill continues; no swap.
REQ-030 vblank edge in same cycle as final transfer -> treated as WAIT_VB on next edge (no swap this edge, no frame_drop).
REQ-031 render_req outside IDLE ignored; render_req in SWAP cycle ignored.
REQ-032 wr_en never targets disp_bank; never both bits high.
REQ-033 disp_bank changes only in SWAP.

Reset
REQ-034 rst=0 at clk edge: state IDLE, fill_x=0, fill_y=0, wr_addr=0, disp_bank=0, vblank history=1 (no spurious edge), all pulses 0, wr_en=0.
REQ-035 Reset mid-FILL abandons frame; no swap, no frame_drop.

Structure
REQ-036 Package graphics_pkg holds state enum, XMAX, YMAX, VACTIVE, FB_ADDR_MAX=XMAX*YMAX-1.
REQ-037 Sub-module fb_fill_counter: x/y/address counters with advance, clear, last outputs.

Verification
REQ-038 Reset, render_req, pix_valid held 1 -> 63360 writes to bank 1, addresses 0..63359 contiguous, WAIT_VB; vc 479->480 -> swap pulse, disp_bank=1.
REQ-039 pix_valid toggled every other cycle -> 63360 writes, 126719-cycle fill, no coordinate skip or repeat.
REQ-040 Fill stalled at wr_addr 1000 across vc=480 -> frame_drop one cycle, disp_bank unchanged, fill resumes at 1000.
REQ-041 Transfer at 63359 coincident with vblank edge -> no swap, no drop; swap at next vc=480.
REQ-042 rst=0 at wr_addr 500 -> all outputs reset values next cycle; render_req restarts at 0.
REQ-043 render_req during FILL and WAIT_VB -> ignored, addresses unperturbed.
